turn_ctrl: RTL

TURN_CTRL -- requirements
Module: turn_ctrl

---
 rtl/turn_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/turn_ctrl.sv
// Turn controller for a two-player artillery game. It takes aim keys, issues
// one frame-aligned launch, and follows the bomb until the turn passes over.
module turn_ctrl #(
    parameter int SETTLE_FRAMES = 30,
    parameter int ACK_TIMEOUT   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       exploded,
    input  logic [9:0] p0X,
    input  logic [9:0] p0Y,
    input  logic [9:0] p1X,
    input  logic [9:0] p1Y,
    output logic       launch,
    output logic [9:0] launchX,
    output logic [9:0] launchY,
    output logic [3:0] angle,
    output logic [2:0] power,
    output logic       player,
    output logic       busy
);

    typedef enum logic [2:0] {AIM, LAUNCH, WAIT_ACK, FLIGHT, SETTLE} state_t;

    localparam logic [7:0] SETTLE_N = 8'(SETTLE_FRAMES);
    localparam logic [7:0] ACK_N    = 8'(ACK_TIMEOUT);

    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            player_q, player_d;
    logic [1:0][3:0] ang_q, ang_d;
    logic [1:0][2:0] pow_q, pow_d;
    logic [9:0]      lx_q, lx_d, ly_q, ly_d;
    logic [2:0]      fsync_q;
    logic [7:0]      key_q, keyp_q;
    logic            frame_tick, key_evt;
    logic [7:0]      cnt_inc;

    // fsync_q[1:0] is the synchronizer; fsync_q[2] holds the prior sample for edge detect
    assign frame_tick = fsync_q[1] & ~fsync_q[2];
    assign key_evt    = (key_q != 8'h00) && (key_q != keyp_q);
    assign cnt_inc    = cnt_q + 8'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= AIM;
            cnt_q    <= 8'd0;
            player_q <= 1'b0;
            ang_q    <= {4'd2, 4'd6};
            pow_q    <= {3'd3, 3'd3};
            lx_q     <= 10'd0;
            ly_q     <= 10'd0;
            fsync_q  <= 3'b000;
            key_q    <= 8'h00;
            keyp_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            player_q <= player_d;
            ang_q    <= ang_d;
            pow_q    <= pow_d;
            lx_q     <= lx_d;
            ly_q     <= ly_d;
            fsync_q  <= {fsync_q[1:0], frame_clk};
            key_q    <= keycode;
            keyp_q   <= key_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        player_d = player_q;
        ang_d    = ang_q;
        pow_d    = pow_q;
        lx_d     = lx_q;
        ly_d     = ly_q;
        case (state_q)
            AIM: begin
                if (key_evt) begin
                    case (key_q)
                        KEY_A: if (ang_q[player_q] != 4'd0) ang_d[player_q] = ang_q[player_q] - 4'd1;
                        KEY_D: if (ang_q[player_q] < 4'd8)  ang_d[player_q] = ang_q[player_q] + 4'd1;
                        KEY_W: if (pow_q[player_q] != 3'd7) pow_d[player_q] = pow_q[player_q] + 3'd1;
                        KEY_S: if (pow_q[player_q] != 3'd0) pow_d[player_q] = pow_q[player_q] - 3'd1;
                        KEY_SPACE: begin
                            if (exploded) begin
                                lx_d    = player_q ? p1X : p0X;
                                ly_d    = player_q ? p1Y : p0Y;
                                state_d = LAUNCH;
                                cnt_d   = 8'd0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            // Hold launch across exactly one frame edge so the bomb sees it once
            LAUNCH: begin
                if (frame_tick) begin
                    state_d = WAIT_ACK;
                    cnt_d   = 8'd0;
                end
            end
            WAIT_ACK: begin
                if (!exploded) begin
                    state_d = FLIGHT;
                    cnt_d   = 8'd0;
                end else if (frame_tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= ACK_N) begin
                        state_d = AIM;
                        cnt_d   = 8'd0;
                    end
                end
            end
            FLIGHT: begin
                if (exploded) begin
                    state_d = SETTLE;
                    cnt_d   = 8'd0;
                end
            end
            SETTLE: begin
                if (frame_tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= SETTLE_N) begin
                        state_d  = AIM;
                        cnt_d    = 8'd0;
                        player_d = ~player_q;
                    end
                end
            end
            default: begin
                state_d = AIM;
                cnt_d   = 8'd0;
            end
        endcase
    end

    assign launch  = (state_q == LAUNCH);
    assign busy    = (state_q != AIM);
    assign player  = player_q;
    assign angle   = ang_q[player_q];
    assign power   = pow_q[player_q];
    assign launchX = lx_q;
    assign launchY = ly_q;

endmodule
